// File: rtl/regfile_sb.sv
// Per-thread register file with write-pending scoreboard for the barrel core.
// Combinational reads with writeback bypass; busy_d flags RAW/WAW hazards.
module regfile_sb #(
    parameter int DATA_WIDTH   = 32,
    parameter int BITS_THREADS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BITS_THREADS-1:0] tid_d,
    input  logic [4:0]              rs1_d,
    input  logic [4:0]              rs2_d,
    input  logic                    use_rs1_d,
    input  logic                    use_rs2_d,
    input  logic [4:0]              rd_d,
    input  logic                    reg_write_d,
    input  logic                    issue_d,
    input  logic                    kill_e,
    input  logic [BITS_THREADS-1:0] tid_e,
    input  logic [4:0]              rd_e,
    input  logic                    reg_write_e,
    input  logic                    reg_write_w,
    input  logic [BITS_THREADS-1:0] tid_w,
    input  logic [4:0]              rd_w,
    input  logic [DATA_WIDTH-1:0]   result_w,
    output logic [DATA_WIDTH-1:0]   rd1_d,
    output logic [DATA_WIDTH-1:0]   rd2_d,
    output logic                    busy_d
);

    localparam int NT = 2 ** BITS_THREADS;

    logic [DATA_WIDTH-1:0] r_regs [NT][32];
    logic [31:0]           r_pend [NT];
    logic [31:0]           w_pend_nxt [NT];

    logic w_wb_tid;
    logic w_hit1;
    logic w_hit2;
    logic w_hitd;
    logic w_haz1;
    logic w_haz2;
    logic w_hazd;
    logic w_accept;

    assign w_wb_tid = reg_write_w && (tid_w == tid_d);
    assign w_hit1   = w_wb_tid && (rd_w == rs1_d);
    assign w_hit2   = w_wb_tid && (rd_w == rs2_d);
    assign w_hitd   = w_wb_tid && (rd_w == rd_d);

    assign rd1_d = (rs1_d == 5'd0) ? '0 :
                   w_hit1 ? result_w : r_regs[tid_d][rs1_d];
    assign rd2_d = (rs2_d == 5'd0) ? '0 :
                   w_hit2 ? result_w : r_regs[tid_d][rs2_d];

    // A register being written back this cycle no longer counts as pending
    assign w_haz1 = use_rs1_d && (rs1_d != 5'd0)
                    && r_pend[tid_d][rs1_d] && !w_hit1;
    assign w_haz2 = use_rs2_d && (rs2_d != 5'd0)
                    && r_pend[tid_d][rs2_d] && !w_hit2;
    assign w_hazd = reg_write_d && (rd_d != 5'd0)
                    && r_pend[tid_d][rd_d] && !w_hitd;

    assign busy_d   = w_haz1 || w_haz2 || w_hazd;
    assign w_accept = issue_d && !busy_d;

    // Set is applied last so it wins over a clear of the same bit
    always_comb begin
        w_pend_nxt = r_pend;
        if (reg_write_w) begin
            w_pend_nxt[tid_w][rd_w] = 1'b0;
        end
        if (kill_e && reg_write_e) begin
            w_pend_nxt[tid_e][rd_e] = 1'b0;
        end
        if (w_accept && reg_write_d && (rd_d != 5'd0)) begin
            w_pend_nxt[tid_d][rd_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NT; t++) begin
                r_pend[t] <= '0;
                for (int r = 0; r < 32; r++) begin
                    r_regs[t][r] <= '0;
                end
            end
        end else begin
            r_pend <= w_pend_nxt;
            if (reg_write_w && (rd_w != 5'd0)) begin
                r_regs[tid_w][rd_w] <= result_w;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then random traffic
// checked against an array-based model of registers and pending bits.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int BT = 3;
    localparam int NT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BT-1:0] tid_d, tid_e, tid_w;
    logic [4:0]    rs1_d, rs2_d, rd_d, rd_e, rd_w;
    logic          use_rs1_d, use_rs2_d, reg_write_d, issue_d;
    logic          kill_e, reg_write_e, reg_write_w;
    logic [DW-1:0] result_w;
    logic [DW-1:0] rd1_d, rd2_d;
    logic          busy_d;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_regs [NT][32];
    bit            m_pend [NT][32];

    regfile_sb #(.DATA_WIDTH(DW), .BITS_THREADS(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .tid_d(tid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .issue_d(issue_d),
        .kill_e(kill_e), .tid_e(tid_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e),
        .reg_write_w(reg_write_w), .tid_w(tid_w), .rd_w(rd_w),
        .result_w(result_w),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .busy_d(busy_d)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < 32; r++) begin
                m_regs[t][r] = '0;
                m_pend[t][r] = 1'b0;
            end
    endtask

    function automatic bit wb_hits(int t, int r);
        return reg_write_w && (int'(tid_w) == t) && (int'(rd_w) == r);
    endfunction

    function automatic logic [DW-1:0] m_read(int r);
        if (r == 0) return '0;
        if (wb_hits(int'(tid_d), r)) return result_w;
        return m_regs[tid_d][r];
    endfunction

    function automatic bit m_waiting(int r);
        return (r != 0) && m_pend[tid_d][r] && !wb_hits(int'(tid_d), r);
    endfunction

    function automatic bit m_busy();
        return (use_rs1_d && m_waiting(int'(rs1_d)))
            || (use_rs2_d && m_waiting(int'(rs2_d)))
            || (reg_write_d && m_waiting(int'(rd_d)));
    endfunction

    task automatic check_all(string tag);
        #1;
        chk({tag, ".rd1"}, rd1_d, m_read(int'(rs1_d)));
        chk({tag, ".rd2"}, rd2_d, m_read(int'(rs2_d)));
        chk({tag, ".busy"}, {31'd0, busy_d}, {31'd0, m_busy()});
    endtask

    // Advance one clock; the model commits using the inputs held across the edge
    task automatic tick();
        bit acc;
        acc = issue_d && !m_busy();
        @(posedge clk);
        if (reg_write_w && rd_w != 0) m_regs[tid_w][rd_w] = result_w;
        if (reg_write_w) m_pend[tid_w][rd_w] = 1'b0;
        if (kill_e && reg_write_e) m_pend[tid_e][rd_e] = 1'b0;
        if (acc && reg_write_d && rd_d != 0) m_pend[tid_d][rd_d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        tid_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
        use_rs1_d = 0; use_rs2_d = 0; reg_write_d = 0; issue_d = 0;
        kill_e = 0; tid_e = '0; rd_e = '0; reg_write_e = 0;
        reg_write_w = 0; tid_w = '0; rd_w = '0; result_w = '0;
    endtask

    task automatic issue(int t, int r);
        idle();
        tid_d = BT'(t); rd_d = 5'(r); reg_write_d = 1; issue_d = 1;
    endtask

    task automatic wb(int t, int r, logic [DW-1:0] v);
        reg_write_w = 1; tid_w = BT'(t); rd_w = 5'(r); result_w = v;
    endtask

    task automatic read1(int t, int r);
        idle();
        tid_d = BT'(t); rs1_d = 5'(r); use_rs1_d = 1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        // 1: reset state
        tid_d = 3'd5; rs1_d = 5'd7; rs2_d = 5'd0; use_rs1_d = 1; use_rs2_d = 1;
        #3;
        chk("rst.rd1", rd1_d, 32'h0);
        chk("rst.rd2", rd2_d, 32'h0);
        chk("rst.busy", {31'd0, busy_d}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: writeback, bank isolation, x0
        idle(); wb(2, 3, 32'hDEADBEEF);
        tid_d = 3'd2; rs1_d = 5'd3;
        check_all("wb.bypass");
        chk("wb.bypass_val", rd1_d, 32'hDEADBEEF);
        tick();
        read1(2, 3);
        check_all("wb.stored");
        chk("wb.stored_val", rd1_d, 32'hDEADBEEF);
        read1(1, 3);
        check_all("wb.other_bank");
        chk("wb.other_bank_val", rd1_d, 32'h0);
        read1(2, 0); wb(2, 0, 32'd5);
        check_all("wb.x0_bypass");
        tick();
        read1(2, 0);
        check_all("wb.x0_after");
        chk("wb.x0_val", rd1_d, 32'h0);

        // 3: RAW on pending register
        issue(4, 9);
        check_all("raw.issue");
        tick();
        read1(4, 9);
        check_all("raw.pending");
        chk("raw.busy_val", {31'd0, busy_d}, 32'h1);
        read1(3, 9);
        check_all("raw.other_tid");
        chk("raw.other_busy", {31'd0, busy_d}, 32'h0);
        read1(4, 9); wb(4, 9, 32'h55);
        check_all("raw.wb_same");
        chk("raw.wb_busy", {31'd0, busy_d}, 32'h0);
        chk("raw.wb_data", rd1_d, 32'h55);
        tick();
        read1(4, 9);
        check_all("raw.cleared");

        // 4: kill clears, WAW blocks, blocked issue has no effect
        issue(1, 6);
        tick();
        idle(); kill_e = 1; tid_e = 3'd1; rd_e = 5'd6; reg_write_e = 1;
        tick();
        read1(1, 6);
        check_all("kill.cleared");
        chk("kill.busy_val", {31'd0, busy_d}, 32'h0);
        issue(1, 6);
        tick();
        issue(1, 6);
        check_all("waw.busy");
        chk("waw.busy_val", {31'd0, busy_d}, 32'h1);
        tick();
        issue(1, 7); rs1_d = 5'd6; use_rs1_d = 1;
        check_all("ign.blocked");
        tick();
        read1(1, 7);
        check_all("ign.no_set");
        chk("ign.no_set_val", {31'd0, busy_d}, 32'h0);
        idle(); kill_e = 1; tid_e = 3'd1; rd_e = 5'd6; reg_write_e = 1;
        wb(1, 6, 32'h66);
        tick();
        read1(1, 6);
        check_all("killwb.cleared");

        // 5: set beats clear on same bit
        issue(0, 12);
        tick();
        issue(0, 12); wb(0, 12, 32'h12);
        check_all("prio.accept");
        tick();
        read1(0, 12);
        check_all("prio.still_pend");
        chk("prio.busy_val", {31'd0, busy_d}, 32'h1);
        idle(); wb(0, 12, 32'h13);
        tick();

        // 6: async reset mid-operation
        issue(2, 4); tick();
        issue(5, 8); wb(5, 8, 32'hABCD); tick();
        issue(7, 31); wb(7, 1, 32'h77); tick();
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            tid_d = (k == 0) ? 3'd2 : (k == 1) ? 3'd5 : 3'd7;
            rs1_d = (k == 0) ? 5'd4 : (k == 1) ? 5'd8 : 5'd31;
            rs2_d = (k == 2) ? 5'd1 : 5'd3;
            use_rs1_d = 1; use_rs2_d = 1;
            check_all("arst");
            chk("arst.rd1_val", rd1_d, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic on a small window of threads/registers
        for (int c = 0; c < 400; c++) begin
            tid_d       = BT'($urandom_range(0, 2));
            rs1_d       = 5'($urandom_range(0, 5));
            rs2_d       = 5'($urandom_range(0, 5));
            rd_d        = 5'($urandom_range(0, 5));
            use_rs1_d   = 1'($urandom);
            use_rs2_d   = 1'($urandom);
            reg_write_d = 1'($urandom);
            issue_d     = ($urandom_range(0, 3) != 0);
            kill_e      = ($urandom_range(0, 4) == 0);
            tid_e       = BT'($urandom_range(0, 2));
            rd_e        = 5'($urandom_range(0, 5));
            reg_write_e = 1'($urandom);
            reg_write_w = ($urandom_range(0, 2) != 0);
            tid_w       = BT'($urandom_range(0, 2));
            rd_w        = 5'($urandom_range(0, 5));
            result_w    = $urandom;
            check_all("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
